mem_loader: RTL and testbench

//  Bus initiator for the picorv32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb).

---
 rtl/mem_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: boot-time bus initiator on the picorv32 native memory interface.
// Packs an incoming byte stream little-endian into 32-bit words and writes them
// to memory starting at a word-aligned base address.
// Optional read-back check of every written word: define MEM_LOADER_VERIFY_EN.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   start, base_addr, len       load request (honoured only when idle)
//   in_valid/in_ready/in_data   byte stream input
//   mem_valid/mem_ready/mem_instr/mem_wstrb/mem_addr/mem_wdata/mem_rdata
//                               native memory bus (initiator side)
//   busy, done, err, count      status: busy, end-of-load pulse, sticky error,
//                               bytes accepted in the current load
module mem_loader #(
    parameter int unsigned LEN_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic             mem_instr,
    output logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] count
);

    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        strb_q, strb_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [TO_W-1:0]   to_cnt, to_cnt_d;
    logic              mem_valid_d, in_ready_d, busy_d, done_d, err_d;
    logic [3:0]        mem_wstrb_d;
    logic [31:0]       mem_addr_d, mem_wdata_d;
    logic [LEN_W-1:0]  count_d;

    assign mem_instr = 1'b0;

`ifndef MEM_LOADER_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    // Next-state and next-output logic
    always_comb begin
        logic       wait_req;
        logic       timed_out;
        logic       finish_word;
        logic [1:0] lane;
        logic [31:0] mask;

        state_d     = state_q;
        strb_d      = strb_q;
        len_d       = len_q;
        mem_valid_d = mem_valid;
        mem_wstrb_d = mem_wstrb;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        count_d     = count;
        err_d       = err;
        done_d      = 1'b0;
        finish_word = 1'b0;
        lane        = count[1:0];
        mask        = '0;

        // Request timeout: counts cycles a request waits for an acknowledge
        wait_req  = mem_valid && !mem_ready;
        timed_out = TO_EN && wait_req && (to_cnt == TO_W'(TO_LAST));
        to_cnt_d  = wait_req ? to_cnt + TO_W'(1) : '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mem_addr_d  = {base_addr[31:2], 2'b00};
                    len_d       = len;
                    count_d     = '0;
                    err_d       = 1'b0;
                    mem_wdata_d = '0;
                    strb_d      = '0;
                    if (len == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (in_valid && in_ready) begin
                    mem_wdata_d[{lane, 3'b000} +: 8] = in_data;
                    strb_d[lane] = 1'b1;
                    count_d      = count + LEN_W'(1);
                    if (lane == 2'd3 || count_d == len_q) begin
                        state_d     = S_WRITE;
                        mem_valid_d = 1'b1;
                        mem_wstrb_d = strb_d;
                    end
                end
            end
            S_WRITE: begin
                if (timed_out) begin
                    mem_valid_d = 1'b0;
                    mem_wstrb_d = '0;
                    err_d       = 1'b1;
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                end else if (mem_valid && mem_ready) begin
                    mem_valid_d = 1'b0;
                    mem_wstrb_d = '0;
`ifdef MEM_LOADER_VERIFY_EN
                    state_d     = S_VERIFY;
`else
                    finish_word = 1'b1;
`endif
                end
            end
`ifdef MEM_LOADER_VERIFY_EN
            // First cycle here is the mandatory idle gap; the read is issued after it
            S_VERIFY: begin
                for (int i = 0; i < 4; i++) begin
                    mask[8*i +: 8] = {8{strb_q[i]}};
                end
                if (timed_out) begin
                    mem_valid_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                end else if (!mem_valid) begin
                    mem_valid_d = 1'b1;
                end else if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    if (((mem_rdata ^ mem_wdata) & mask) != '0) begin
                        err_d = 1'b1;
                    end
                    finish_word = 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Word complete: advance address, clear lanes, continue or finish
        if (finish_word) begin
            mem_addr_d  = mem_addr + 32'd4;
            mem_wdata_d = '0;
            strb_d      = '0;
            if (count == len_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = S_COLLECT;
            end
        end

        in_ready_d = (state_d == S_COLLECT);
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            strb_q    <= '0;
            len_q     <= '0;
            to_cnt    <= '0;
            mem_valid <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            state_q   <= state_d;
            strb_q    <= strb_d;
            len_q     <= len_d;
            to_cnt    <= to_cnt_d;
            mem_valid <= mem_valid_d;
            mem_wstrb <= mem_wstrb_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            count     <= count_d;
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Testbench for mem_loader: directed loads against a bus responder model that
// acknowledges one cycle after a request is raised.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        busy, done, err;
    logic [15:0] count;

    mem_loader #(.LEN_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_instr(mem_instr),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    int n_checks = 0;
    int n_pass   = 0;

    wr_t         wlog[$];
    logic [31:0] mem_model [logic [31:0]];
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          valid_cyc = 0;
    int          run_len = 0;
    int          last_run = 0;
    int          unstable = 0;
    logic        resp_on = 1'b1;
    logic        corrupt = 1'b0;
    logic [31:0] h_addr, h_data;
    logic [3:0]  h_strb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Responder and monitor, evaluated away from the active edge
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_valid) begin
            valid_cyc++;
            if (run_len == 0) begin
                h_addr = mem_addr; h_data = mem_wdata; h_strb = mem_wstrb;
            end else if (h_addr !== mem_addr || h_data !== mem_wdata || h_strb !== mem_wstrb) begin
                unstable++;
            end
            run_len++;
            if (resp_on && run_len == 2) begin
                mem_ready = 1'b1;
                if (mem_wstrb != 4'h0) begin
                    wlog.push_back('{mem_addr, mem_wdata, mem_wstrb});
                    mem_model[mem_addr] = mem_wdata;
                end else begin
                    rd_cnt++;
                    mem_rdata = (mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0)
                                ^ (corrupt ? 32'h00FF_0000 : 32'h0);
                end
            end
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len   = 0;
            mem_ready = 1'b0;
        end
    end

    task automatic do_start(input logic [31:0] b, input logic [15:0] l);
        @(negedge clk);
        base_addr = b; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("stream_stall", 32'd0, 32'd1);
    endtask

    task automatic send_seq(input int n, input logic [7:0] first, input int restart_at);
        for (int i = 0; i < n; i++) begin
            if (i == restart_at) begin
                in_valid = 1'b0;
                base_addr = 32'hDEAD_0000; len = 16'd3; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send(8'(first + 8'(i * 'h11)));
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (done_cnt > d0) begin ok = 1'b1; break; end
        end
        if (!ok) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_wr(input int idx, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (wlog.size() <= idx) begin
            check("wr_missing", 32'(wlog.size()), 32'(idx + 1));
        end else begin
            check("wr_addr", wlog[idx].addr, a);
            check("wr_data", wlog[idx].data, d);
            check("wr_strb", 32'(wlog[idx].strb), 32'(s));
        end
    endtask

    task automatic run_basic(input int restart_at, input string tag);
        int d0;
        wlog.delete();
        d0 = done_cnt;
        do_start(32'h100, 16'd8);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        send_seq(8, 8'h11, restart_at);
        wait_done(d0);
        check({tag, "_nwr"}, 32'(wlog.size()), 32'd2);
        check_wr(0, 32'h100, 32'h4433_2211, 4'hF);
        check_wr(1, 32'h104, 32'h8877_6655, 4'hF);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd8);
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_ndone"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int d0;
        int v0;
        bit seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_status", {28'd0, busy, done, err, in_ready}, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_bus", mem_addr | mem_wdata | 32'(mem_wstrb) | 32'(mem_instr), 32'd0);
        resetn = 1'b1;

        // Two full words, then the same load with a start pulse during it
        run_basic(-1, "basic");
        run_basic(4, "restart");

        // Unaligned base and a partial trailing word
        wlog.delete();
        d0 = done_cnt;
        do_start(32'h203, 16'd5);
        send_seq(5, 8'h11, -1);
        wait_done(d0);
        check("part_nwr", 32'(wlog.size()), 32'd2);
        check_wr(0, 32'h200, 32'h4433_2211, 4'hF);
        check_wr(1, 32'h204, 32'h0000_0055, 4'b0001);
        check("part_count", 32'(count), 32'd5);

        // Zero length: immediate done, no bus request
        d0 = done_cnt;
        v0 = valid_cyc;
        do_start(32'h300, 16'd0);
        #1;
        check("len0_done", 32'(done), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        check("len0_ndone", 32'(done_cnt - d0), 32'd1);
        check("len0_novalid", 32'(valid_cyc - v0), 32'd0);
        check("len0_busy", 32'(busy), 32'd0);

        // Timeout: responder never acknowledges; fifth byte must stay unconsumed
        wlog.delete();
        resp_on = 1'b0;
        d0 = done_cnt;
        do_start(32'h400, 16'd8);
        send_seq(4, 8'h11, -1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        wait_done(d0);
        check("to_valid_cycles", 32'(last_run), 32'd16);
        check("to_err", 32'(err), 32'd1);
        check("to_valid_low", 32'(mem_valid), 32'd0);
        repeat (5) @(negedge clk);
        #1;
        check("to_count", 32'(count), 32'd4);
        check("to_inready", 32'(in_ready), 32'd0);
        check("to_nwr", 32'(wlog.size()), 32'd0);
        in_valid = 1'b0;
        resp_on  = 1'b1;

        // err is cleared by the next accepted start
        do_start(32'h480, 16'd4);
        check("err_clear", 32'(err), 32'd0);
        d0 = done_cnt;
        send_seq(4, 8'h11, -1);
        wait_done(d0);

        // Reset asserted while a write is pending, then a clean load
        resp_on = 1'b0;
        do_start(32'h500, 16'd4);
        send_seq(4, 8'h11, -1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("rstw_valid_seen", 32'(seen), 32'd1);
        resetn = 1'b0;
        #1;
        check("rstw_valid", 32'(mem_valid), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);
        @(negedge clk);
        resetn  = 1'b1;
        resp_on = 1'b1;
        wlog.delete();
        d0 = done_cnt;
        do_start(32'h600, 16'd4);
        send_seq(4, 8'hA1, -1);
        wait_done(d0);
        check("rstw_nwr", 32'(wlog.size()), 32'd1);
        check_wr(0, 32'h600, 32'hD4C3_B2A1, 4'hF);
        check("rstw_err", 32'(err), 32'd0);

`ifdef MEM_LOADER_VERIFY_EN
        // Read-back with lane 2 corrupted by the responder
        wlog.delete();
        corrupt = 1'b1;
        v0 = rd_cnt;
        d0 = done_cnt;
        do_start(32'h700, 16'd8);
        send_seq(8, 8'h11, -1);
        wait_done(d0);
        check("vfy_nwr", 32'(wlog.size()), 32'd2);
        check("vfy_nrd", 32'(rd_cnt - v0), 32'd2);
        check("vfy_err", 32'(err), 32'd1);
        check("vfy_count", 32'(count), 32'd8);
        corrupt = 1'b0;
`else
        check("no_reads", 32'(rd_cnt), 32'd0);
`endif

        check("bus_stable", 32'(unstable), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
